// File: rtl/ncr_slave_bridge.sv
// ============================================================================
//  Module      : ncr_slave_bridge
//  Description : Turns a decoded Zorro III slave access to the SCSI register
//                window into the SREG/AS/DS strobe sequence of the NCR 53C710
//                register port. Derives SIZ/A[1:0] from the Zorro byte lanes,
//                waits for SLACK_n with a timeout, and reports completion
//                (scsi_dtack) or failure (scsi_berr) to the slave FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ncr_slave_bridge #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       scsi_cycle,
  input  logic       FCS_n,
  input  logic       READ,
  input  logic [3:0] DS_n,
  input  logic       SLACK_n,
  output logic       SCSI_SREG_n,
  output logic       SCSI_AS_n,
  output logic       SCSI_DS_n,
  output logic [1:0] SCSI_SIZ,
  output logic [1:0] SCSI_A,
  output logic       scsi_dtack,
  output logic       scsi_berr,
  output logic       busy
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_STROBE   = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4,
    ST_RECOVER  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic       start_q, start_d;   // start sampled in IDLE; acted on one edge later
  logic       read_q,  read_d;
  logic [1:0] siz_q,   siz_d;
  logic [1:0] a_q,     a_d;
  logic       berr_q,  berr_d;    // illegal lanes or timeout; shown only in DONE
  logic [7:0] cnt_q,   cnt_d;

  logic [1:0] lane_siz;
  logic [1:0] lane_a;
  logic       lane_ok;

  // Byte-lane decode: reads are always longword, writes map DS_n to SIZ/A.
  always_comb begin
    lane_siz = 2'b00;
    lane_a   = 2'b00;
    lane_ok  = 1'b1;
    if (!READ) begin
      case (DS_n)
        4'b0111: begin lane_siz = 2'b01; lane_a = 2'b00; end
        4'b1011: begin lane_siz = 2'b01; lane_a = 2'b01; end
        4'b1101: begin lane_siz = 2'b01; lane_a = 2'b10; end
        4'b1110: begin lane_siz = 2'b01; lane_a = 2'b11; end
        4'b0011: begin lane_siz = 2'b10; lane_a = 2'b00; end
        4'b1100: begin lane_siz = 2'b10; lane_a = 2'b10; end
        4'b0001: begin lane_siz = 2'b11; lane_a = 2'b00; end
        4'b1000: begin lane_siz = 2'b11; lane_a = 2'b01; end
        4'b0000: begin lane_siz = 2'b00; lane_a = 2'b00; end
        default: lane_ok = 1'b0;
      endcase
    end
  end

  // Next-state logic: strobe sequencing, ack/timeout handling and abort on FCS_n.
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    read_d  = read_q;
    siz_d   = siz_q;
    a_d     = a_q;
    berr_d  = berr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_q) begin
          start_d = 1'b0;
          state_d = berr_q ? ST_DONE : ST_SETUP;
        end else if (scsi_cycle && !FCS_n && (READ || DS_n != 4'b1111)) begin
          start_d = 1'b1;
          read_d  = READ;
          siz_d   = lane_siz;
          a_d     = lane_a;
          berr_d  = !lane_ok;
        end
      end
      ST_SETUP:  state_d = FCS_n ? ST_RECOVER : ST_STROBE;
      ST_STROBE: state_d = FCS_n ? ST_RECOVER : ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        cnt_d = cnt_q + 8'd1;
        if (FCS_n) begin
          state_d = ST_RECOVER;
        end else if (!SLACK_n) begin
          state_d = ST_DONE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_DONE;
          berr_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (FCS_n) state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        start_d = 1'b0;
        cnt_d   = 8'd0;
        berr_d  = 1'b0;
        siz_d   = 2'b00;
        a_d     = 2'b00;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched-access registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      read_q  <= 1'b0;
      siz_q   <= 2'b00;
      a_q     <= 2'b00;
      berr_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      read_q  <= read_d;
      siz_q   <= siz_d;
      a_q     <= a_d;
      berr_q  <= berr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode directly from state so an asynchronous reset releases them at once.
  always_comb begin
    SCSI_SREG_n = !(state_q == ST_SETUP || state_q == ST_STROBE || state_q == ST_WAIT_ACK);
    SCSI_AS_n   = !(state_q == ST_STROBE || state_q == ST_WAIT_ACK);
    SCSI_DS_n   = !((state_q == ST_STROBE && read_q) || state_q == ST_WAIT_ACK);
    if (state_q == ST_SETUP || state_q == ST_STROBE ||
        state_q == ST_WAIT_ACK || state_q == ST_DONE) begin
      SCSI_SIZ = siz_q;
      SCSI_A   = a_q;
    end else begin
      SCSI_SIZ = 2'b00;
      SCSI_A   = 2'b00;
    end
    scsi_dtack = (state_q == ST_DONE);
    scsi_berr  = (state_q == ST_DONE) && berr_q;
    busy       = (state_q != ST_IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_ncr_slave_bridge.sv
// ============================================================================
//  Module      : tb_ncr_slave_bridge
//  Description : Directed self-checking bench for ncr_slave_bridge. Edge 0 is
//                the clock edge that samples the start condition.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ncr_slave_bridge;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       scsi_cycle;
  logic       FCS_n;
  logic       READ;
  logic [3:0] DS_n;
  logic       SLACK_n;
  wire        SCSI_SREG_n;
  wire        SCSI_AS_n;
  wire        SCSI_DS_n;
  wire  [1:0] SCSI_SIZ;
  wire  [1:0] SCSI_A;
  wire        scsi_dtack;
  wire        scsi_berr;
  wire        busy;

  int n_checks = 0;
  int n_errors = 0;

  // {SREG_n, AS_n, DS_n, dtack, berr, busy} and {SIZ, A}
  wire [5:0] ctl = {SCSI_SREG_n, SCSI_AS_n, SCSI_DS_n, scsi_dtack, scsi_berr, busy};
  wire [3:0] sa  = {SCSI_SIZ, SCSI_A};

  ncr_slave_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RESET(RESET), .scsi_cycle(scsi_cycle), .FCS_n(FCS_n), .READ(READ),
    .DS_n(DS_n), .SLACK_n(SLACK_n), .SCSI_SREG_n(SCSI_SREG_n), .SCSI_AS_n(SCSI_AS_n),
    .SCSI_DS_n(SCSI_DS_n), .SCSI_SIZ(SCSI_SIZ), .SCSI_A(SCSI_A),
    .scsi_dtack(scsi_dtack), .scsi_berr(scsi_berr), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; scsi_cycle = 1'b0; FCS_n = 1'b1; READ = 1'b0; DS_n = 4'hF; SLACK_n = 1'b1;
    step(); step();
    n_checks++; if (ctl !== 6'b111000) begin n_errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b111000); end
    n_checks++; if (sa !== 4'b0000) begin n_errors++; $display("FAIL reset_sa: got %b expected %b", sa, 4'b0000); end
    RESET = 1'b0;
    step();
    n_checks++; if (ctl !== 6'b111000) begin n_errors++; $display("FAIL reset_release: got %b expected %b", ctl, 6'b111000); end
  endtask

  task automatic test_long_read();
    scsi_cycle = 1'b1; FCS_n = 1'b0; READ = 1'b1; DS_n = 4'b1101;
    step(); // edge 0
    n_checks++; if (ctl !== 6'b111000) begin n_errors++; $display("FAIL rd_e0: got %b expected %b", ctl, 6'b111000); end
    step(); // edge 1
    n_checks++; if (ctl !== 6'b011001) begin n_errors++; $display("FAIL rd_e1: got %b expected %b", ctl, 6'b011001); end
    n_checks++; if (sa !== 4'b0000) begin n_errors++; $display("FAIL rd_sizA: got %b expected %b", sa, 4'b0000); end
    step(); // edge 2
    n_checks++; if (ctl !== 6'b000001) begin n_errors++; $display("FAIL rd_e2: got %b expected %b", ctl, 6'b000001); end
    step(); // edge 3
    n_checks++; if (ctl !== 6'b000001) begin n_errors++; $display("FAIL rd_e3: got %b expected %b", ctl, 6'b000001); end
    SLACK_n = 1'b0;
    step(); // edge 4
    n_checks++; if (ctl !== 6'b111101) begin n_errors++; $display("FAIL rd_e4: got %b expected %b", ctl, 6'b111101); end
    SLACK_n = 1'b1;
    step();
    n_checks++; if (ctl !== 6'b111101) begin n_errors++; $display("FAIL rd_hold: got %b expected %b", ctl, 6'b111101); end
    FCS_n = 1'b1; scsi_cycle = 1'b0;
    step();
    n_checks++; if (ctl !== 6'b111001) begin n_errors++; $display("FAIL rd_recover: got %b expected %b", ctl, 6'b111001); end
    step();
    n_checks++; if (ctl !== 6'b111000) begin n_errors++; $display("FAIL rd_idle: got %b expected %b", ctl, 6'b111000); end
  endtask

  task automatic test_byte_write();
    scsi_cycle = 1'b1; FCS_n = 1'b0; READ = 1'b0; DS_n = 4'b1101;
    step(); // edge 0
    step(); // edge 1
    n_checks++; if (ctl !== 6'b011001) begin n_errors++; $display("FAIL wr_e1: got %b expected %b", ctl, 6'b011001); end
    n_checks++; if (sa !== 4'b0110) begin n_errors++; $display("FAIL wr_sizA: got %b expected %b", sa, 4'b0110); end
    step(); // edge 2: AS only
    n_checks++; if (ctl !== 6'b001001) begin n_errors++; $display("FAIL wr_e2: got %b expected %b", ctl, 6'b001001); end
    step(); // edge 3: DS joins
    n_checks++; if (ctl !== 6'b000001) begin n_errors++; $display("FAIL wr_e3: got %b expected %b", ctl, 6'b000001); end
    SLACK_n = 1'b0;
    step(); // edge 4
    n_checks++; if (ctl !== 6'b111101) begin n_errors++; $display("FAIL wr_e4: got %b expected %b", ctl, 6'b111101); end
    n_checks++; if (sa !== 4'b0110) begin n_errors++; $display("FAIL wr_sizA_done: got %b expected %b", sa, 4'b0110); end
    SLACK_n = 1'b1; FCS_n = 1'b1; scsi_cycle = 1'b0;
    step();
    n_checks++; if (sa !== 4'b0000) begin n_errors++; $display("FAIL wr_sizA_recover: got %b expected %b", sa, 4'b0000); end
    step();
  endtask

  task automatic test_lanes();
    logic [3:0] ds_tab [9] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b0011,
                               4'b1100, 4'b0001, 4'b1000, 4'b0000};
    logic [3:0] sa_tab [9] = '{4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000,
                               4'b1010, 4'b1100, 4'b1101, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      scsi_cycle = 1'b1; FCS_n = 1'b0; READ = 1'b0; DS_n = ds_tab[i];
      step(); step(); // edges 0,1
      n_checks++; if (sa !== sa_tab[i]) begin n_errors++; $display("FAIL lane_%b: got %b expected %b", ds_tab[i], sa, sa_tab[i]); end
      step(); step(); // edges 2,3
      SLACK_n = 1'b0;
      step(); // edge 4
      n_checks++; if (ctl !== 6'b111101) begin n_errors++; $display("FAIL lane_done_%b: got %b expected %b", ds_tab[i], ctl, 6'b111101); end
      SLACK_n = 1'b1; FCS_n = 1'b1; scsi_cycle = 1'b0;
      step(); step();
    end
  endtask

  task automatic test_timeout();
    scsi_cycle = 1'b1; FCS_n = 1'b0; READ = 1'b1; DS_n = 4'b0000;
    SLACK_n = 1'b0; // stale ack before WAIT_ACK must be ignored
    step(); step(); step(); step(); // edges 0..3, WAIT_ACK entered at edge 3
    n_checks++; if (ctl !== 6'b000001) begin n_errors++; $display("FAIL tmo_stale: got %b expected %b", ctl, 6'b000001); end
    SLACK_n = 1'b1;
    for (int i = 0; i < 7; i++) step(); // edge 10
    n_checks++; if (ctl !== 6'b000001) begin n_errors++; $display("FAIL tmo_early: got %b expected %b", ctl, 6'b000001); end
    step(); // edge 11 = WAIT_ACK entry + 8
    n_checks++; if (ctl !== 6'b111111) begin n_errors++; $display("FAIL tmo_done: got %b expected %b", ctl, 6'b111111); end
    FCS_n = 1'b1; scsi_cycle = 1'b0;
    step();
    n_checks++; if (ctl !== 6'b111001) begin n_errors++; $display("FAIL tmo_recover: got %b expected %b", ctl, 6'b111001); end
    step();
  endtask

  task automatic test_illegal_write();
    scsi_cycle = 1'b1; FCS_n = 1'b0; READ = 1'b0; DS_n = 4'b1001;
    step(); // edge 0
    n_checks++; if (ctl !== 6'b111000) begin n_errors++; $display("FAIL ill_e0: got %b expected %b", ctl, 6'b111000); end
    step(); // edge 1
    n_checks++; if (ctl !== 6'b111111) begin n_errors++; $display("FAIL ill_e1: got %b expected %b", ctl, 6'b111111); end
    step();
    n_checks++; if (ctl !== 6'b111111) begin n_errors++; $display("FAIL ill_hold: got %b expected %b", ctl, 6'b111111); end
    FCS_n = 1'b1; scsi_cycle = 1'b0;
    step();
    n_checks++; if (ctl !== 6'b111001) begin n_errors++; $display("FAIL ill_recover: got %b expected %b", ctl, 6'b111001); end
    step();
  endtask

  task automatic test_abort();
    scsi_cycle = 1'b1; FCS_n = 1'b0; READ = 1'b1; DS_n = 4'b0000;
    step(); step(); step(); step(); // in WAIT_ACK
    FCS_n = 1'b1; scsi_cycle = 1'b0;
    step();
    n_checks++; if (ctl !== 6'b111001) begin n_errors++; $display("FAIL abort_recover: got %b expected %b", ctl, 6'b111001); end
    SLACK_n = 1'b0;
    step();
    n_checks++; if (ctl !== 6'b111000) begin n_errors++; $display("FAIL abort_idle: got %b expected %b", ctl, 6'b111000); end
    step();
    n_checks++; if (ctl !== 6'b111000) begin n_errors++; $display("FAIL abort_stale: got %b expected %b", ctl, 6'b111000); end
    SLACK_n = 1'b1;
  endtask

  task automatic test_reset_mid_cycle();
    scsi_cycle = 1'b1; FCS_n = 1'b0; READ = 1'b1; DS_n = 4'b0000;
    step(); step(); step(); // STROBE
    n_checks++; if (ctl !== 6'b000001) begin n_errors++; $display("FAIL mrst_strobe: got %b expected %b", ctl, 6'b000001); end
    #2;
    RESET = 1'b1; scsi_cycle = 1'b0; FCS_n = 1'b1;
    #1;
    n_checks++; if (ctl !== 6'b111000) begin n_errors++; $display("FAIL mrst_async: got %b expected %b", ctl, 6'b111000); end
    step();
    RESET = 1'b0;
    step();
    scsi_cycle = 1'b1; FCS_n = 1'b0; READ = 1'b0; DS_n = 4'b0011;
    step(); step(); // edges 0,1
    n_checks++; if (sa !== 4'b1000) begin n_errors++; $display("FAIL mrst_sizA: got %b expected %b", sa, 4'b1000); end
    step(); step(); // edges 2,3
    SLACK_n = 1'b0;
    step(); // edge 4
    n_checks++; if (ctl !== 6'b111101) begin n_errors++; $display("FAIL mrst_done: got %b expected %b", ctl, 6'b111101); end
    SLACK_n = 1'b1; FCS_n = 1'b1; scsi_cycle = 1'b0;
    step(); step();
  endtask

  task automatic test_back_to_back();
    scsi_cycle = 1'b1; FCS_n = 1'b0; READ = 1'b1; DS_n = 4'b0000;
    step(); step(); step(); step();
    SLACK_n = 1'b0;
    step(); // DONE
    SLACK_n = 1'b1; FCS_n = 1'b1;
    step(); // RECOVER
    FCS_n = 1'b0; // new cycle requested immediately
    step(); // back in IDLE, request not taken in RECOVER
    n_checks++; if (ctl !== 6'b111000) begin n_errors++; $display("FAIL b2b_idle: got %b expected %b", ctl, 6'b111000); end
    step(); // start sampled in IDLE
    n_checks++; if (ctl !== 6'b111000) begin n_errors++; $display("FAIL b2b_e0: got %b expected %b", ctl, 6'b111000); end
    step();
    n_checks++; if (ctl !== 6'b011001) begin n_errors++; $display("FAIL b2b_e1: got %b expected %b", ctl, 6'b011001); end
    step(); step();
    SLACK_n = 1'b0;
    step();
    n_checks++; if (ctl !== 6'b111101) begin n_errors++; $display("FAIL b2b_done: got %b expected %b", ctl, 6'b111101); end
    SLACK_n = 1'b1; FCS_n = 1'b1; scsi_cycle = 1'b0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_long_read();
    test_byte_write();
    test_lanes();
    test_timeout();
    test_illegal_write();
    test_abort();
    test_reset_mid_cycle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
